// File: rtl/adc_axis_if.sv
// Valid-only sample stream carrying the packed {ch_b, ch_a} word toward pdh_core.
interface adc_axis_if #(
   parameter int W = 32
);
   logic [W-1:0] tdata;
   logic         tvalid;

   modport master (output tdata, output tvalid);
   modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/adc_axis_adapter.sv
// Red Pitaya ADC front end: offset-binary to two's complement, optional 2^D block
// averaging, valid-only stream out, sticky per-channel rail flags.
module adc_axis_lane #(
   parameter int ADC_WIDTH = 14,
   parameter int OUT_WIDTH = 16,
   parameter int AW        = 22,
   parameter int DW        = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADC_WIDTH-1:0] raw_i,
   input  logic                 v1_i,
   input  logic                 v2_i,
   input  logic                 first_i,
   input  logic                 last_i,
   input  logic                 clr_i,
   input  logic [DW-1:0]        d_i,
   output logic [OUT_WIDTH-1:0] dout_o,
   output logic                 clip_o
);
   logic [ADC_WIDTH-1:0]        raw_q;
   logic signed [OUT_WIDTH-1:0] s2;
   logic signed [AW-1:0]        acc, acc_nx, shd;
   logic [OUT_WIDTH-1:0]        sat_v;
   logic                        rail;

   assign rail = (raw_q == '0) || (raw_q == '1);

   always_comb begin
      acc_nx = (first_i ? '0 : acc) + {{(AW-OUT_WIDTH){s2[OUT_WIDTH-1]}}, s2};
      shd    = acc_nx >>> d_i;
      sat_v  = shd[OUT_WIDTH-1:0];
      // Guard only: a mean of 14-bit codes always fits in 16 bits.
      if (!(&shd[AW-1:OUT_WIDTH-1] || ~|shd[AW-1:OUT_WIDTH-1]))
         sat_v = shd[AW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_q  <= '0;
         s2     <= '0;
         acc    <= '0;
         dout_o <= '0;
         clip_o <= 1'b0;
      end else begin
         raw_q <= raw_i;
         s2    <= {{(OUT_WIDTH-ADC_WIDTH+1){~raw_q[ADC_WIDTH-1]}}, raw_q[ADC_WIDTH-2:0]};
         if (v2_i) begin
            acc <= acc_nx;
            if (last_i) dout_o <= sat_v;
         end else begin
            acc <= '0;
         end
         // A rail hit in the same cycle as a clear keeps the flag set.
         if (v1_i && rail) clip_o <= 1'b1;
         else if (clr_i)   clip_o <= 1'b0;
      end
   end
endmodule

module adc_axis_adapter #(
   parameter int ADC_WIDTH    = 14,
   parameter int OUT_WIDTH    = 16,
   parameter int MAX_DEC_LOG2 = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADC_WIDTH-1:0] adc_dat_a_i,
   input  logic [ADC_WIDTH-1:0] adc_dat_b_i,
   input  logic                 cfg_en_i,
   input  logic [3:0]           dec_log2_i,
   input  logic                 clip_clr_i,
   adc_axis_if.master           m_axis,
   output logic                 clip_a_o,
   output logic                 clip_b_o
);
   localparam int NUM_LANES = 2;
   localparam int STAGES    = 2;
   localparam int AW        = ADC_WIDTH + MAX_DEC_LOG2;
   localparam int CW        = MAX_DEC_LOG2 + 1;

   logic [STAGES-1:0]                         vld_pipe;
   logic [NUM_LANES-1:0][ADC_WIDTH-1:0]       raw;
   logic [NUM_LANES-1:0][OUT_WIDTH-1:0]       dout;
   logic [NUM_LANES-1:0]                      clip;
   logic [CW-1:0]                             cnt;
   logic [3:0]                                d_q, d_clamp, d_eff;
   logic                                      first, last, tvalid_q;

   assign raw     = {adc_dat_b_i, adc_dat_a_i};
   assign d_clamp = (dec_log2_i > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : dec_log2_i;
   // The window's D is sampled only on its first sample; later changes wait.
   assign first   = (cnt == '0);
   assign d_eff   = first ? d_clamp : d_q;
   assign last    = (cnt == (CW'(1) << d_eff) - CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         cnt      <= '0;
         d_q      <= '0;
         tvalid_q <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-2:0], cfg_en_i};
         if (vld_pipe[STAGES-1]) begin
            if (first) d_q <= d_clamp;
            cnt      <= last ? '0 : cnt + CW'(1);
            tvalid_q <= last;
         end else begin
            // An invalid sample drops any partial window.
            cnt      <= '0;
            tvalid_q <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      adc_axis_lane #(
         .ADC_WIDTH (ADC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .AW        (AW),
         .DW        (4)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (raw[i]),
         .v1_i    (vld_pipe[0]),
         .v2_i    (vld_pipe[STAGES-1]),
         .first_i (first),
         .last_i  (last),
         .clr_i   (clip_clr_i),
         .d_i     (d_eff),
         .dout_o  (dout[i]),
         .clip_o  (clip[i])
      );
   end

   assign m_axis.tdata  = dout;
   assign m_axis.tvalid = tvalid_q;
   assign clip_a_o      = clip[0];
   assign clip_b_o      = clip[1];
endmodule

// File: doc/adc_axis_adapter.md
Name: adc_axis_adapter

Overview:
Upstream feeder of pdh_core. It registers the raw 14-bit Red Pitaya ADC channels and converts each from offset binary to two's complement, sign-extended to 16 bits. It optionally block-averages by 2^D and emits the pair as a 32-bit valid-only stream on pdh_axis_tdata/pdh_axis_tvalid. It also keeps sticky per-channel clip flags for the PS.

Parameters:
ADC_WIDTH, 14, raw ADC code width per channel
OUT_WIDTH, 16, sign-extended sample width per channel (matches pdh_core ADC_DATA_WIDTH)
MAX_DEC_LOG2, 8, largest averaging exponent; accumulator width = ADC_WIDTH+MAX_DEC_LOG2

Ports:
clk  in  1  ADC-domain clock (pdh_clk)
rst_n  in  1  asynchronous active-low reset
adc_dat_a_i  in  14  channel A raw code, offset binary
adc_dat_b_i  in  14  channel B raw code, offset binary
cfg_en_i  in  1  stream enable
dec_log2_i  in  4  averaging exponent D; values >MAX_DEC_LOG2 clamp to MAX_DEC_LOG2
clip_clr_i  in  1  clears both clip flags
m_axis_tdata  out  32  {ch_b[15:0], ch_a[15:0]}
m_axis_tvalid  out  1  one-cycle pulse per output word
clip_a_o  out  1  sticky: channel A hit a rail
clip_b_o  out  1  sticky: channel B hit a rail

Behaviour:
- Reset is asynchronous and active-low. All outputs, pipeline registers, the accumulators, the counter and the latched D are 0 under reset.
- Stage 1: register the raw inputs every cycle. The stage-1 valid flag is the registered value of cfg_en_i.
- Stage 2: convert each channel by inverting the MSB, then sign-extend to 16 bits. Code 0x2000 converts to 0, 0x3FFF to +8191, and 0x0000 to -8192 (0xE000).
- Clip detection: a stage-1 valid sample with raw code 0x0000 or 0x3FFF sets its clip flag.
  - clip_clr_i clears both flags.
  - If a clip and clip_clr_i occur in the same cycle, the set wins.
- Stage 3, averaging, with a counter cnt and signed 22-bit accumulators per channel:
  - D is latched from dec_log2_i (after clamping) only when cnt==0 and a valid sample arrives. A change to dec_log2_i mid-window never affects the window in progress.
  - If cnt==0: acc <= s. Otherwise: acc <= acc + s.
  - If cnt == 2^D - 1:
    - tdata <= sat16((acc + s) >>> D), using an arithmetic shift (floor toward -inf).
    - tvalid <= 1 and cnt <= 0.
  - Otherwise: cnt <= cnt + 1 and tvalid <= 0.
  - With D=0, every sample is output directly.
  - sat16 never triggers for a 14-bit average; it is kept as a guard.
- Latency: 3 clocks from a sample at the input to the tvalid pulse that contains it as the last sample of its window.
  - With D=0: a sample presented before edge k gives tvalid=1 during the cycle after edge k+2.
- Throughput:
  - With D=0, tvalid may be high every cycle.
  - Otherwise tvalid goes high once per 2^D valid samples.
- m_axis_tdata holds its last value between pulses.
- There is no tready. The consumer must accept every pulse, matching the valid-only pdh_core input.
- cfg_en_i deassert:
  - Samples stop being counted from the next stage-1 capture.
  - cnt and the accumulators reset to 0 when the first invalid sample reaches stage 3, so a partial window is discarded and never emitted.
  - Samples already in the pipeline with valid set still complete: at most 2 trailing pulses with D=0.
- cfg_en_i reassert: a new window starts at cnt==0 with D latched at that point.
- Reset asserted mid-window: all state clears immediately and tvalid drops asynchronously.

Test Plan:
- Conversion, D=0, en=1:
  - A=0x2000, B=0x3FFF → tdata=0x1FFF_0000 exactly 3 clocks later.
  - A=0x0000, B=0x2001 → tdata=0x0001_E000.
  - tvalid high every cycle.
- Averaging, D=2:
  - A = 0x2004, 0x2008, 0x200C, 0x2010 → a single pulse with ch_a=0x000A.
  - Then A = 0x1FFF×3 followed by 0x1FFE (sum -5) → ch_a=0xFFFE (floor).
  - tvalid exactly once per 4 samples.
- D change mid-window: D=3 latched; switch dec_log2_i to 0 after 3 samples → the 8-sample window completes with one pulse, after which every sample emits. dec_log2_i=15 → behaves as D=8: one pulse per 256 samples.
- Enable gating:
  - D=2, deassert cfg_en_i after 2 samples, then reassert → no pulse from the partial window.
  - The next pulse equals the average of the first 4 samples after reassert.
- Clip flags:
  - A=0x3FFF for one cycle sets clip_a_o; clip_b_o stays 0.
  - clip_clr_i with no clip clears clip_a_o.
  - clip_clr_i in the same cycle as A=0x0000 leaves clip_a_o=1.
- Async reset mid-window: assert rst_n=0 between edges during a D=4 window → all outputs 0 immediately. After release, the first pulse comes only after 16 fresh samples.
